roberts_cross_sched: RTL and testbench
======================================

Name: roberts_cross_sched

Overview:
- Sequencing controller for the stochastic-computing Roberts cross `core`.
- Accepts 2x2 pixel windows over a valid/ready stream and latches them onto the core inputs.
- Drives the core `rst`/`en` per operation and counts enabled cycles.
- Ends each operation on `op_finished` or on a programmable cycle budget (early-termination accuracy tradeoff).
- Returns result, cycle count and truncation flag over a valid/ready stream, and keeps running statistics for average-latency and error characterisation.

Parameters:
- DATA_WIDTH, 8, pixel and result width.
- CNT_WIDTH, 16, per-operation cycle counter and budget width.
- STAT_WIDTH, 32, statistics counter and accumulator width.

Ports:
- gclk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  window valid.
- in_ready  out  1  scheduler can accept a window.
- in_px00, in_px01, in_px10, in_px11  in  DATA_WIDTH each  window pixels.
- cfg_max_cycles  in  CNT_WIDTH  cycle budget; 0 = unlimited.
- core_rst  out  1  to core rst.
- core_en  out  1  to core en.
- core_in00, core_in01, core_in10, core_in11  out  DATA_WIDTH each  to core bin_in*.
- core_data_out  in  DATA_WIDTH  core bin_data_out.
- core_op_finished  in  1  core op_finished.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_WIDTH  captured core result.
- out_cycles  out  CNT_WIDTH  enabled cycles used.
- out_truncated  out  1  terminated by budget or saturation, not by finish.
- busy  out  1  state != IDLE.
- stat_clr  in  1  clear statistics.
- stat_ops  out  STAT_WIDTH  completed operations.
- stat_trunc  out  STAT_WIDTH  truncated operations.
- stat_cyc_acc  out  STAT_WIDTH  sum of out_cycles.

Behaviour:
- Interface: one clock, gclk; reset rst is synchronous, active-high.
- Reset state: IDLE, in_ready=1 from the first cycle after reset, core_rst=1, core_en=0. All other outputs, core_in* and stats are 0. Any in-flight operation is discarded with no output.
- States: IDLE, CLEAR, RUN, OUT.
- IDLE: in_ready=1, core_rst=1, core_en=0.
  - On in_valid&in_ready: latch the pixels into core_in*, latch cfg_max_cycles into an internal budget, go to CLEAR.
  - cfg changes after acceptance have no effect.
- CLEAR: exactly 1 cycle. core_rst=1, core_en=0, counter cleared to 0. Go to RUN.
- RUN: core_rst=0, core_en=1, counter increments every cycle; k = 1-based index of the current RUN cycle. Terminate at the end of cycle k when any of these holds:
  - core_op_finished=1;
  - budget!=0 and k==budget;
  - k==2^CNT_WIDTH-1 (saturation).
- On termination:
  - Capture out_data=core_data_out, out_cycles=k.
  - out_truncated = !core_op_finished.
  - Go to OUT.
  - If finish and budget coincide, finish wins, so truncated=0.
  - core_en is low from the next cycle.
- OUT: out_valid=1, core_rst=1, core_en=0, in_ready=0; out_data, out_cycles and out_truncated stable.
  - On out_ready go to IDLE.
  - out_valid drops the cycle after the handshake.
- Latency: handshake at edge N, CLEAR in cycle N+1, RUN cycles N+2..N+1+k, out_valid from cycle N+2+k.
- Throughput: one window per k+3 cycles when out_ready is held high.
- core_in* hold their value until the next acceptance.
- Statistics:
  - Updated on the termination edge: stat_ops+=1; stat_trunc+=out_truncated; stat_cyc_acc+=k.
  - All three saturate at max.
  - stat_clr zeroes them next cycle. If stat_clr coincides with an update, clear wins.
  - rst also clears them.
- Output handshake follows the standard valid/ready rule: out_valid is never withdrawn before out_ready.

Test Plan:
- Reset:
  - Hold rst 2 cycles, release.
  - Required: in_ready=1, out_valid=0, core_rst=1, core_en=0, all stats 0.
- Full accuracy:
  - Window 10,200,30,40, budget 0, behavioural core finishing at k=200 with data 200.
  - Required: exactly 1 CLEAR cycle; core_en high for exactly 200 cycles; out_data=200, out_cycles=200, out_truncated=0; stat_cyc_acc=200.
- Budget truncation:
  - Budget 64, core finishing at 200, core_data_out=64 at k=64.
  - Required: out_cycles=64, out_truncated=1, out_data=64, stat_trunc=1.
  - Then set cfg_max_cycles=5 during OUT: next op still uses the value latched at its acceptance.
- Coincident finish and budget at k=64:
  - Required: out_truncated=0.
  - After the 3 ops above: stat_ops=3, stat_trunc=1, stat_cyc_acc=328.
- Backpressure:
  - out_ready=0 for 10 cycles with in_valid=1.
  - Required: out_valid and data stable, in_ready=0, core_en=0; after out_ready=1, IDLE, then the next window is accepted.
- Reset mid-RUN:
  - Assert rst at RUN k=30.
  - Required: next cycle IDLE, core_rst=1, core_en=0, no out_valid, stats 0.
  - A subsequent op completes normally.

Source files
------------

// File: rtl/roberts_cross_sched.sv
`default_nettype none
// ============================================================================
//  Module      : roberts_cross_sched
//  Description : Sequencing controller for a stochastic-computing Roberts
//                cross core. It accepts 2x2 windows over valid/ready and
//                drives the core reset/enable for each operation. Each
//                operation ends on op_finished, on the cycle budget, or on
//                counter saturation. The result, the cycle count and the
//                truncation flag go out over valid/ready, and the block
//                keeps running latency and error statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module roberts_cross_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  gclk,
    input  logic                  rst,
    // window input stream
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_px00,
    input  logic [DATA_WIDTH-1:0] in_px01,
    input  logic [DATA_WIDTH-1:0] in_px10,
    input  logic [DATA_WIDTH-1:0] in_px11,
    input  logic [CNT_WIDTH-1:0]  cfg_max_cycles,
    // core side
    output logic                  core_rst,
    output logic                  core_en,
    output logic [DATA_WIDTH-1:0] core_in00,
    output logic [DATA_WIDTH-1:0] core_in01,
    output logic [DATA_WIDTH-1:0] core_in10,
    output logic [DATA_WIDTH-1:0] core_in11,
    input  logic [DATA_WIDTH-1:0] core_data_out,
    input  logic                  core_op_finished,
    // result output stream
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_cycles,
    output logic                  out_truncated,
    output logic                  busy,
    // statistics
    input  logic                  stat_clr,
    output logic [STAT_WIDTH-1:0] stat_ops,
    output logic [STAT_WIDTH-1:0] stat_trunc,
    output logic [STAT_WIDTH-1:0] stat_cyc_acc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  c_cnt_one  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  c_cnt_max  = '1;
    localparam logic [STAT_WIDTH-1:0] c_stat_one = STAT_WIDTH'(1);
    localparam logic [STAT_WIDTH-1:0] c_stat_max = '1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   r_budget;
    logic [CNT_WIDTH-1:0]   w_k;
    logic                   w_accept;
    logic                   w_term;
    logic [STAT_WIDTH-1:0]  w_trunc_inc;

    // 1-based index of the RUN cycle in progress
    assign w_k         = r_cnt + c_cnt_one;
    assign busy        = (r_state != S_IDLE);
    assign w_trunc_inc = core_op_finished ? '0 : c_stat_one;

    // Statistics saturate instead of wrapping so long runs stay meaningful
    function automatic logic [STAT_WIDTH-1:0] sat_add(
        input logic [STAT_WIDTH-1:0] a,
        input logic [STAT_WIDTH-1:0] b
    );
        logic [STAT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STAT_WIDTH] ? c_stat_max : s[STAT_WIDTH-1:0];
    endfunction

    // State register
    always_ff @(posedge gclk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/core control decode
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        core_rst    = 1'b1;
        core_en     = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_term      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                core_rst = 1'b0;
                core_en  = 1'b1;
                // finish wins over budget: it is what decides out_truncated
                w_term   = core_op_finished
                         | ((r_budget != '0) && (w_k == r_budget))
                         | (w_k == c_cnt_max);
                if (w_term) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Window/budget latch, RUN cycle counter and result capture
    always_ff @(posedge gclk) begin
        if (rst) begin
            core_in00     <= '0;
            core_in01     <= '0;
            core_in10     <= '0;
            core_in11     <= '0;
            r_budget      <= '0;
            r_cnt         <= '0;
            out_data      <= '0;
            out_cycles    <= '0;
            out_truncated <= 1'b0;
        end else begin
            if (w_accept) begin
                core_in00 <= in_px00;
                core_in01 <= in_px01;
                core_in10 <= in_px10;
                core_in11 <= in_px11;
                r_budget  <= cfg_max_cycles;
            end
            if (r_state == S_CLEAR) begin
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= w_k;
            end
            if (w_term) begin
                out_data      <= core_data_out;
                out_cycles    <= w_k;
                out_truncated <= ~core_op_finished;
            end
        end
    end

    // Running statistics; a clear takes priority over a same-cycle update
    always_ff @(posedge gclk) begin
        if (rst || stat_clr) begin
            stat_ops     <= '0;
            stat_trunc   <= '0;
            stat_cyc_acc <= '0;
        end else if (w_term) begin
            stat_ops     <= sat_add(stat_ops, c_stat_one);
            stat_trunc   <= sat_add(stat_trunc, w_trunc_inc);
            stat_cyc_acc <= sat_add(stat_cyc_acc, STAT_WIDTH'(w_k));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_roberts_cross_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_roberts_cross_sched
//  Description : Scoreboard bench for roberts_cross_sched with a behavioural
//                core model and a queue of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_roberts_cross_sched;

    logic        gclk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [7:0]  in_px00, in_px01, in_px10, in_px11;
    logic [15:0] cfg_max_cycles;
    logic        core_rst, core_en;
    logic [7:0]  core_in00, core_in01, core_in10, core_in11;
    logic [7:0]  core_data_out;
    logic        core_op_finished;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic [15:0] out_cycles;
    logic        out_truncated, busy, stat_clr;
    logic [31:0] stat_ops, stat_trunc, stat_cyc_acc;

    always #5 gclk = ~gclk;

    roberts_cross_sched dut (
        .gclk(gclk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_px00(in_px00), .in_px01(in_px01), .in_px10(in_px10), .in_px11(in_px11),
        .cfg_max_cycles(cfg_max_cycles),
        .core_rst(core_rst), .core_en(core_en),
        .core_in00(core_in00), .core_in01(core_in01), .core_in10(core_in10), .core_in11(core_in11),
        .core_data_out(core_data_out), .core_op_finished(core_op_finished),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cycles(out_cycles), .out_truncated(out_truncated),
        .busy(busy), .stat_clr(stat_clr),
        .stat_ops(stat_ops), .stat_trunc(stat_trunc), .stat_cyc_acc(stat_cyc_acc)
    );

    // Behavioural core: counts its enabled cycles, finishes at cycle fin_k and
    // presents (cycle index + off) as its running result.
    logic [15:0] core_cnt;
    int          fin_k;
    logic [7:0]  off;

    always @(posedge gclk) begin
        if (core_rst) core_cnt <= 16'd0;
        else if (core_en) core_cnt <= core_cnt + 16'd1;
    end
    always_comb begin
        core_op_finished = ((32'(core_cnt) + 32'd1) == 32'(fin_k));
        core_data_out    = 8'(core_cnt + 16'd1 + {8'd0, off});
    end

    typedef struct {
        logic [7:0] data;
        int         cycles;
        bit         trunc;
        int         ops, trn, acc;
        logic [7:0] p0, p1, p2, p3;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_ops = 0, m_trn = 0, m_acc = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: cycle accounting per operation and result comparison
    int         en_cnt = 0, clr_cnt = 0;
    bit         hold = 0, drop_chk = 0;
    logic [7:0] sv_data;
    logic [15:0] sv_cyc;
    logic       sv_tr;

    always @(negedge gclk) begin
        if (rst) begin
            q.delete();
            hold = 0; drop_chk = 0; en_cnt = 0; clr_cnt = 0;
        end else begin
            if (drop_chk) begin
                chk("valid_drop", longint'(out_valid), 0);
                drop_chk = 0;
            end
            if (in_valid && in_ready) begin
                en_cnt = 0; clr_cnt = 0;
            end else begin
                if (core_en) en_cnt++;
                if (busy && core_rst && !out_valid) clr_cnt++;
            end
            if (out_valid) begin
                if (!hold) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = q[0];
                        chk("out_data",      longint'(out_data),      longint'(e.data));
                        chk("out_cycles",    longint'(out_cycles),    longint'(e.cycles));
                        chk("out_truncated", longint'(out_truncated), longint'(e.trunc));
                        chk("en_cycles",     longint'(en_cnt),        longint'(e.cycles));
                        chk("clear_cycles",  longint'(clr_cnt),       1);
                        chk("stat_ops",      longint'(stat_ops),      longint'(e.ops));
                        chk("stat_trunc",    longint'(stat_trunc),    longint'(e.trn));
                        chk("stat_cyc_acc",  longint'(stat_cyc_acc),  longint'(e.acc));
                        chk("core_in",
                            longint'({core_in00, core_in01, core_in10, core_in11}),
                            longint'({e.p0, e.p1, e.p2, e.p3}));
                    end
                    sv_data = out_data; sv_cyc = out_cycles; sv_tr = out_truncated;
                    hold = 1;
                end else begin
                    chk("hold_data",  longint'(out_data),      longint'(sv_data));
                    chk("hold_cyc",   longint'(out_cycles),    longint'(sv_cyc));
                    chk("hold_trunc", longint'(out_truncated), longint'(sv_tr));
                    chk("out_in_ready", longint'(in_ready), 0);
                    chk("out_core_en",  longint'(core_en),  0);
                end
                if (out_ready) begin
                    if (q.size() != 0) void'(q.pop_front());
                    hold = 0;
                    drop_chk = 1;
                end
            end
        end
    end

    // Issue one window; the expected response comes straight from the rules:
    // k = min(finish, budget if nonzero, 65535), truncated unless finish reached.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input int bud, input int fin,
                        input logic [7:0] o, input bit clr_stats);
        exp_t x;
        int   k;
        bit   acc;
        @(posedge gclk); #1;
        in_px00 = a; in_px01 = b; in_px10 = c; in_px11 = d;
        cfg_max_cycles = 16'(bud); fin_k = fin; off = o; in_valid = 1'b1;
        acc = 0;
        for (int t = 0; t < 3000 && !acc; t++) begin
            @(negedge gclk);
            acc = in_ready;
        end
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        k = fin;
        if (bud != 0 && bud < k) k = bud;
        if (k > 65535) k = 65535;
        x.cycles = k;
        x.trunc  = (k != fin);
        x.data   = 8'((k + int'(o)) % 256);
        if (clr_stats) begin
            m_ops = 0; m_trn = 0; m_acc = 0;
        end else begin
            m_ops += 1; m_trn += int'(x.trunc); m_acc += k;
        end
        x.ops = m_ops; x.trn = m_trn; x.acc = m_acc;
        x.p0 = a; x.p1 = b; x.p2 = c; x.p3 = d;
        q.push_back(x);
        @(posedge gclk); #1;
        in_valid = 1'b0;
        cfg_max_cycles = 16'd5;   // must not affect the accepted op
    endtask

    task automatic wait_done();
        bit done;
        done = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge gclk);
            done = (q.size() == 0) && in_ready;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_out_valid();
        bit seen;
        seen = 0;
        for (int t = 0; t < 3000 && !seen; t++) begin
            @(negedge gclk);
            seen = out_valid;
        end
        if (!seen) chk("out_valid_timeout", 0, 1);
    endtask

    initial begin
        int n, bud, fin;
        rst = 1'b1; in_valid = 1'b0; in_px00 = 0; in_px01 = 0; in_px10 = 0; in_px11 = 0;
        cfg_max_cycles = 0; out_ready = 1'b1; stat_clr = 1'b0; fin_k = 1000000; off = 0;

        // Reset
        repeat (2) @(posedge gclk);
        #1 rst = 1'b0;
        @(negedge gclk);
        chk("rst_in_ready",  longint'(in_ready),  1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_core_rst",  longint'(core_rst),  1);
        chk("rst_core_en",   longint'(core_en),   0);
        chk("rst_stats",     longint'(stat_ops | stat_trunc | stat_cyc_acc), 0);
        chk("rst_outs",      longint'({out_data, out_cycles, out_truncated, core_in00}), 0);

        // Full accuracy, budget truncation, coincident finish/budget
        send(8'd10, 8'd200, 8'd30, 8'd40, 0, 200, 8'd0, 0);
        wait_done();
        send(8'd1, 8'd2, 8'd3, 8'd4, 64, 200, 8'd0, 0);
        wait_done();
        send(8'd5, 8'd6, 8'd7, 8'd8, 64, 64, 8'd0, 0);
        wait_done();
        chk("three_ops",   longint'(stat_ops),     3);
        chk("three_trunc", longint'(stat_trunc),   1);
        chk("three_acc",   longint'(stat_cyc_acc), 328);

        // Randomised operations
        for (int i = 0; i < 12; i++) begin
            fin = int'($urandom_range(1, 300));
            bud = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 300));
            if ($urandom_range(0, 4) == 0) bud = fin;
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 bud, fin, 8'($urandom), 0);
            wait_done();
        end

        // Backpressure with a pending window
        @(posedge gclk); #1 out_ready = 1'b0;
        send(8'd11, 8'd22, 8'd33, 8'd44, 0, 20, 8'd7, 0);
        wait_out_valid();
        @(posedge gclk); #1;
        in_px00 = 8'd55; in_px01 = 8'd66; in_px10 = 8'd77; in_px11 = 8'd88;
        cfg_max_cycles = 16'd9; fin_k = 40; off = 8'd3; in_valid = 1'b1;
        repeat (10) begin
            @(negedge gclk);
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_in_ready",  longint'(in_ready),  0);
        end
        @(posedge gclk); #1 out_ready = 1'b1;
        send(8'd55, 8'd66, 8'd77, 8'd88, 9, 40, 8'd3, 0);
        wait_done();

        // Statistics clear in IDLE
        @(posedge gclk); #1 stat_clr = 1'b1;
        @(posedge gclk); #1 stat_clr = 1'b0;
        @(negedge gclk);
        chk("clr_stats", longint'(stat_ops | stat_trunc | stat_cyc_acc), 0);
        m_ops = 0; m_trn = 0; m_acc = 0;

        // Clear held across a termination edge: clear wins
        send(8'd9, 8'd8, 8'd7, 8'd6, 10, 30, 8'd1, 1);
        @(posedge gclk); #1 stat_clr = 1'b1;
        wait_out_valid();
        @(posedge gclk); #1 stat_clr = 1'b0;
        wait_done();

        // Reset in RUN cycle k=30
        send(8'd100, 8'd101, 8'd102, 8'd103, 0, 200, 8'd0, 0);
        n = 0;
        for (int t = 0; t < 1000 && n < 30; t++) begin
            @(negedge gclk);
            if (core_en) n++;
        end
        rst = 1'b1;
        @(negedge gclk);
        chk("mid_rst_in_ready",  longint'(in_ready),  1);
        chk("mid_rst_core_rst",  longint'(core_rst),  1);
        chk("mid_rst_core_en",   longint'(core_en),   0);
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_stats",     longint'(stat_ops | stat_trunc | stat_cyc_acc), 0);
        @(posedge gclk); #1 rst = 1'b0;
        m_ops = 0; m_trn = 0; m_acc = 0;
        repeat (3) begin
            @(negedge gclk);
            chk("post_rst_no_out", longint'(out_valid), 0);
        end
        send(8'd12, 8'd34, 8'd56, 8'd78, 50, 45, 8'd2, 0);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
